// File: rtl/lane_collision_detector.sv
// Collision detector for the lane/hit interface: compares every lane's pixel row
// against the frog position and latches a collision into hit/game_over.
module lane_collision_detector #(
    parameter int NUM_LANES      = 4,
    parameter int COLS           = 16,
    parameter int GRACE_CYCLES   = 3,
    parameter int CONFIRM_CYCLES = 2,
    localparam int COL_W         = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_LANES*COLS-1:0]  lane_pixels,
    input  logic [NUM_LANES-1:0]       frog_lane,
    input  logic [COL_W-1:0]           frog_col,
    output logic [NUM_LANES-1:0]       hit,
    output logic                       game_over,
    output logic [LANE_W-1:0]          hit_lane
);

    localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
    localparam int CW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam logic [GW-1:0] GRACE_LAST   = GW'(GRACE_CYCLES - 1);
    localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_CYCLES - 1);

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        WATCH   = 2'd1,
        CONFIRM = 2'd2,
        DEAD    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grace_q, grace_d;
    logic [CW-1:0]         confirm_q, confirm_d;
    logic [NUM_LANES-1:0]  hit_q, hit_d;
    logic                  game_over_q, game_over_d;
    logic [LANE_W-1:0]     hit_lane_q, hit_lane_d;
    logic [NUM_LANES-1:0]  prev_lane_q, prev_lane_d;
    logic [COL_W-1:0]      prev_col_q, prev_col_d;

    logic                  onehot_s;
    logic                  col_ok_s;
    logic                  overlap_s;
    logic                  moved_s;
    logic                  go_dead_s;
    logic [LANE_W-1:0]     lane_idx_s;
    logic [COLS-1:0]       row_s;

    // Overlap and movement detection for the current frog position
    always_comb begin
        lane_idx_s = '0;
        row_s      = '0;
        onehot_s   = (frog_lane != '0) &&
                     ((frog_lane & (frog_lane - NUM_LANES'(1))) == '0);
        col_ok_s   = (int'(frog_col) < COLS);
        for (int i = 0; i < NUM_LANES; i++) begin
            if (frog_lane[i]) begin
                lane_idx_s = LANE_W'(i);
                row_s      = lane_pixels[i*COLS +: COLS];
            end else begin
                lane_idx_s = lane_idx_s;
            end
        end
        overlap_s = onehot_s && col_ok_s && row_s[frog_col];
        moved_s   = (frog_lane != prev_lane_q) || (frog_col != prev_col_q);
    end

    // Next-state logic; moved always wins over overlap, DEAD only leaves via reset
    always_comb begin
        state_d     = state_q;
        grace_d     = grace_q;
        confirm_d   = confirm_q;
        hit_d       = hit_q;
        game_over_d = game_over_q;
        hit_lane_d  = hit_lane_q;
        prev_lane_d = prev_lane_q;
        prev_col_d  = prev_col_q;
        go_dead_s   = 1'b0;
        if (enable) begin
            prev_lane_d = frog_lane;
            prev_col_d  = frog_col;
            case (state_q)
                ARMING: begin
                    if (moved_s) begin
                        grace_d = '0;
                    end else if (grace_q == GRACE_LAST) begin
                        state_d = WATCH;
                    end else begin
                        grace_d = grace_q + GW'(1);
                    end
                end
                WATCH: begin
                    if (moved_s) begin
                        state_d = ARMING;
                        grace_d = '0;
                    end else if (overlap_s && (CONFIRM_CYCLES == 1)) begin
                        go_dead_s = 1'b1;
                    end else if (overlap_s) begin
                        state_d   = CONFIRM;
                        confirm_d = CW'(1);
                    end else begin
                        state_d = WATCH;
                    end
                end
                CONFIRM: begin
                    if (moved_s) begin
                        state_d   = ARMING;
                        grace_d   = '0;
                        confirm_d = '0;
                    end else if (!overlap_s) begin
                        state_d = WATCH;
                    end else if (confirm_q == CONFIRM_LAST) begin
                        go_dead_s = 1'b1;
                    end else begin
                        confirm_d = confirm_q + CW'(1);
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                default: begin
                    state_d = ARMING;
                end
            endcase
            if (go_dead_s) begin
                state_d     = DEAD;
                hit_d       = '1;
                game_over_d = 1'b1;
                hit_lane_d  = lane_idx_s;
            end else begin
                hit_d = hit_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARMING;
            grace_q     <= '0;
            confirm_q   <= '0;
            hit_q       <= '0;
            game_over_q <= 1'b0;
            hit_lane_q  <= '0;
            prev_lane_q <= '0;
            prev_col_q  <= '0;
        end else begin
            state_q     <= state_d;
            grace_q     <= grace_d;
            confirm_q   <= confirm_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
            hit_lane_q  <= hit_lane_d;
            prev_lane_q <= prev_lane_d;
            prev_col_q  <= prev_col_d;
        end
    end

    assign hit       = hit_q;
    assign game_over = game_over_q;
    assign hit_lane  = hit_lane_q;

endmodule

// File: tb/tb_lane_collision_detector.sv
// Directed bench for lane_collision_detector; expected outputs are hand-computed
// from the grace/confirm rules (3 grace cycles, 2 confirm cycles).
module tb_lane_collision_detector;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [63:0] lane_pixels;
    logic [3:0]  frog_lane;
    logic [3:0]  frog_col;
    logic [3:0]  hit;
    logic        game_over;
    logic [1:0]  hit_lane;

    int checks;
    int errors;

    lane_collision_detector dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .lane_pixels (lane_pixels),
        .frog_lane   (frog_lane),
        .frog_col    (frog_col),
        .hit         (hit),
        .game_over   (game_over),
        .hit_lane    (hit_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_hit,
                           input logic e_go, input logic [1:0] e_lane);
        chk({tag, ".hit"}, {28'd0, hit}, {28'd0, e_hit});
        chk({tag, ".game_over"}, {31'd0, game_over}, {31'd0, e_go});
        chk({tag, ".hit_lane"}, {30'd0, hit_lane}, {30'd0, e_lane});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        lane_pixels = 64'h0000_0000_0000_0004;
        frog_lane   = 4'b0001;
        frog_col    = 4'd2;

        // 1: first edge sees a move (prev = 0), grace 0,1,2, WATCH, CONFIRM, DEAD
        @(negedge clk);
        chk_out("reset_state", 4'b0000, 1'b0, 2'd0);
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            step();
            chk(($sformatf("t1_edge%0d", e)), {28'd0, hit}, 32'd0);
        end
        step();
        chk_out("t1_dead", 4'b1111, 1'b1, 2'd0);

        // 2: car removed mid-confirm returns to WATCH; restore needs two more edges
        do_reset();
        for (int e = 1; e <= 5; e++) step();
        chk_out("t2_in_confirm", 4'b0000, 1'b0, 2'd0);
        lane_pixels = 64'h0000_0000_0000_0000;
        step();
        chk_out("t2_car_gone", 4'b0000, 1'b0, 2'd0);
        lane_pixels = 64'h0000_0000_0000_0004;
        step();
        chk_out("t2_reconfirm1", 4'b0000, 1'b0, 2'd0);
        step();
        chk_out("t2_reconfirm2", 4'b1111, 1'b1, 2'd0);

        // 3: stepping onto a car in lane 2 from WATCH restarts the grace period
        lane_pixels = 64'h0000_0008_0000_0000;
        frog_lane   = 4'b0001;
        frog_col    = 4'd2;
        do_reset();
        for (int e = 1; e <= 4; e++) step();
        frog_lane = 4'b0100;
        frog_col  = 4'd3;
        for (int e = 5; e <= 9; e++) begin
            step();
            chk(($sformatf("t3_edge%0d", e)), {31'd0, game_over}, 32'd0);
        end
        step();
        chk_out("t3_dead", 4'b1111, 1'b1, 2'd2);

        // 4: disabled edges inside the confirm run hold everything
        lane_pixels = 64'h0000_0000_0000_0000;
        frog_lane   = 4'b0001;
        frog_col    = 4'd2;
        do_reset();
        for (int e = 1; e <= 4; e++) step();
        lane_pixels = 64'h0000_0000_0000_0004;
        step();
        chk_out("t4_en1", 4'b0000, 1'b0, 2'd0);
        enable = 1'b0;
        step();
        chk_out("t4_en0a", 4'b0000, 1'b0, 2'd0);
        step();
        chk_out("t4_en0b", 4'b0000, 1'b0, 2'd0);
        enable = 1'b1;
        step();
        chk_out("t4_en1b", 4'b1111, 1'b1, 2'd0);

        // 6: DEAD ignores inputs, then async reset clears outputs before the next edge
        frog_lane   = 4'b1000;
        frog_col    = 4'd9;
        lane_pixels = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        step();
        chk_out("t6_dead_hold", 4'b1111, 1'b1, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("t6_async_reset", 4'b0000, 1'b0, 2'd0);
        @(negedge clk);

        // 5: two-hot or empty frog_lane never produces a hit
        lane_pixels = 64'h0000_0000_0020_0020;
        frog_lane   = 4'b0011;
        frog_col    = 4'd5;
        do_reset();
        for (int e = 0; e < 25; e++) step();
        chk_out("t5_twohot", 4'b0000, 1'b0, 2'd0);
        frog_lane = 4'b0000;
        for (int e = 0; e < 25; e++) step();
        chk_out("t5_nolane", 4'b0000, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
